seg_scan_ctrl: RTL

//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//   It holds a double-buffered hex display value and steps one digit at a time through a refresh slot.

---
 rtl/seg_scan_ctrl_if.sv | 24 ++
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Purpose: user-side and pin-side signals of the 7-segment scan controller.
// Latency: none, wiring only.
// Backpressure: none; load is a single-cycle strobe with no ready.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_mask;
  logic                  load;
  logic [N_DIGITS-1:0]   digit_en;
  logic [N_DIGITS-1:0]   dig;
  logic [7:0]            segments;
  logic                  frame_tick;

  modport master (
    output value, dp_mask, load, digit_en,
    input  dig, segments, frame_tick
  );

  modport slave (
    input  value, dp_mask, load, digit_en,
    output dig, segments, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Purpose: time-multiplexed N-digit common-anode 7-segment scanner with double-buffered hex value.
// Latency: dig/segments registered, one cycle behind cnt/idx; loads become visible after the next frame boundary.
// Backpressure: none; load is accepted every cycle and the last load before a frame boundary wins.
module seg_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter int BLANK    = 16
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } slot_state_t;

  slot_state_t state, state_d;

  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d;
  logic          slot_end;
  logic          frame_end;

  logic [N_DIGITS-1:0][3:0] shadow_val;
  logic [N_DIGITS-1:0][3:0] active_val;
  logic [N_DIGITS-1:0]      shadow_dp;
  logic [N_DIGITS-1:0]      active_dp;
  logic                     pending;

  logic [N_DIGITS-1:0] dig_q, dig_d;
  logic [7:0]          seg_q, seg_d;
  logic                tick_q;

  // Hex nibble to active-low {dp,g,f,e,d,c,b,a}; dp is left dark here.
  function automatic logic [7:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0:    return 8'hc0;
      4'h1:    return 8'hf9;
      4'h2:    return 8'ha4;
      4'h3:    return 8'hb0;
      4'h4:    return 8'h99;
      4'h5:    return 8'h92;
      4'h6:    return 8'h82;
      4'h7:    return 8'hf8;
      4'h8:    return 8'h80;
      4'h9:    return 8'h90;
      4'ha:    return 8'h88;
      4'hb:    return 8'h83;
      4'hc:    return 8'hc6;
      4'hd:    return 8'ha1;
      4'he:    return 8'h86;
      default: return 8'h8e;
    endcase
  endfunction

  assign slot_end  = (cnt == CW'(DIV - 1));
  assign frame_end = slot_end && (idx == IW'(N_DIGITS - 1));

  // Next scan position, slot phase and the pin values for the current position.
  always_comb begin
    cnt_d   = slot_end ? '0 : cnt + CW'(1);
    idx_d   = idx;
    if (slot_end) begin
      idx_d = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
    end
    state_d = (32'(cnt_d) < BLANK) ? ST_BLANK : ST_SHOW;

    dig_d = '1;
    seg_d = 8'hff;
    // digit_en is used live so a digit can be muted without waiting for a frame.
    if (state == ST_SHOW && bus.digit_en[idx]) begin
      dig_d = ~(N_DIGITS'(1) << idx);
      seg_d = hex2seg(active_val[idx]) & {~active_dp[idx], 7'h7f};
    end
  end

  // Scan counters and slot phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      state <= (BLANK > 0) ? ST_BLANK : ST_SHOW;
    end else begin
      cnt   <= cnt_d;
      idx   <= idx_d;
      state <= state_d;
    end
  end

  // Shadow/active double buffer; active only ever changes at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else if (frame_end && bus.load) begin
      // A load landing on the boundary itself bypasses the shadow wait.
      shadow_val <= bus.value;
      shadow_dp  <= bus.dp_mask;
      active_val <= bus.value;
      active_dp  <= bus.dp_mask;
      pending    <= 1'b0;
    end else if (frame_end && pending) begin
      active_val <= shadow_val;
      active_dp  <= shadow_dp;
      pending    <= 1'b0;
    end else if (bus.load) begin
      shadow_val <= bus.value;
      shadow_dp  <= bus.dp_mask;
      pending    <= 1'b1;
    end
  end

  // Registered pin drivers so a digit switch never shows two digits low together.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q  <= '1;
      seg_q  <= 8'hff;
      tick_q <= 1'b0;
    end else begin
      dig_q  <= dig_d;
      seg_q  <= seg_d;
      tick_q <= frame_end;
    end
  end

  assign bus.dig        = dig_q;
  assign bus.segments   = seg_q;
  assign bus.frame_tick = tick_q;

endmodule
